// File: rtl/alu_sbm_seq_if.sv
// Operation type shared with alu_sbm, plus the request/response bundle
// between execute-stage control (master) and alu_sbm_seq (slave).
package alu_sbm_pkg;
  typedef enum logic [3:0] {
    ALU_OP_ADD    = 4'd0,
    ALU_OP_SUB    = 4'd1,
    ALU_OP_PLUS_4 = 4'd2,
    ALU_OP_AND    = 4'd3,
    ALU_OP_OR     = 4'd4,
    ALU_OP_XOR    = 4'd5,
    ALU_OP_EQ     = 4'd6,
    ALU_OP_LT     = 4'd7,
    ALU_OP_LTU    = 4'd8,
    ALU_OP_SLL    = 4'd9,
    ALU_OP_SRL    = 4'd10,
    ALU_OP_SRA    = 4'd11
  } cs_alu_op;
endpackage

interface alu_sbm_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  alu_sbm_pkg::cs_alu_op req_op_i;
  logic                  req_cmp_flip_i;
  logic [DATA_W-1:0]     req_a_i;
  logic [DATA_W-1:0]     req_b_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [DATA_W-1:0]     resp_result_o;
  logic                  resp_cmp_o;

  modport master (
    output req_valid_i, req_op_i, req_cmp_flip_i, req_a_i, req_b_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_result_o, resp_cmp_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_cmp_flip_i, req_a_i, req_b_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_result_o, resp_cmp_o
  );
endinterface

// File: rtl/alu_sbm_seq.sv
// Runs one 32-bit ALU operation as two 16-bit passes through alu_sbm.
// Optional: define ALU_SEQ_EARLY_CMP_EN to let EQ finish after pass 0.
module alu_sbm_seq
  import alu_sbm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned HALF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_sbm_seq_if.slave      bus,
  output cs_alu_op          alu_op_o,
  output logic              alu_first_cycle_o,
  output logic              alu_cmp_flip_o,
  output logic [HALF_W-1:0] alu_a_o,
  output logic [HALF_W-1:0] alu_b_o,
  input  logic [HALF_W-1:0] alu_result_i,
  input  logic              alu_cmp_result_i,
  input  logic              alu_cmp_result_valid_i
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P0   = 2'd1,
    S_P1   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  cs_alu_op          r_op;
  cs_alu_op          w_req_op;
  logic              r_flip;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic              r_cmp;
  logic              r_cmp_held;

  logic              w_is_cmp;
  logic              w_is_shift;
  logic              w_hi_first;
  logic              w_big_sh;
  logic              w_early;
  logic [HALF_W-1:0] w_a_lo;
  logic [HALF_W-1:0] w_a_hi;
  logic [HALF_W-1:0] w_a_p0;
  logic [HALF_W-1:0] w_a_p1;
  logic [HALF_W-1:0] w_b_p0;
  logic [HALF_W-1:0] w_b_p1;
  logic [HALF_W-1:0] w_b_sh;

  // Unknown encodings collapse to ADD at accept, so the ALU never sees them.
  always_comb begin
    w_req_op = ALU_OP_ADD;
    case (bus.req_op_i)
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_PLUS_4, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
      ALU_OP_EQ, ALU_OP_LT, ALU_OP_LTU, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA:
        w_req_op = bus.req_op_i;
      default: w_req_op = ALU_OP_ADD;
    endcase
  end

  assign w_is_cmp   = (r_op == ALU_OP_EQ) || (r_op == ALU_OP_LT) || (r_op == ALU_OP_LTU);
  assign w_hi_first = (r_op == ALU_OP_SRL) || (r_op == ALU_OP_SRA);
  assign w_is_shift = w_hi_first || (r_op == ALU_OP_SLL);
  assign w_big_sh   = r_b[SH_W-1];
  assign w_a_lo     = r_a[HALF_W-1:0];
  assign w_a_hi     = r_a[DATA_W-1:HALF_W];
  assign w_b_sh     = {{(HALF_W-SH_W){1'b0}}, r_b[SH_W-1:0]};

`ifdef ALU_SEQ_EARLY_CMP_EN
  assign w_early = (r_op == ALU_OP_EQ) && alu_cmp_result_valid_i;
`else
  assign w_early = 1'b0;
`endif

  // Shifts of 16 or more: pass 0 feeds only fill bits, pass 1 feeds the
  // half that lands in the result, so the ALU only ever shifts by b[3:0].
  always_comb begin
    w_a_p0 = w_hi_first ? w_a_hi : w_a_lo;
    w_a_p1 = w_hi_first ? w_a_lo : w_a_hi;
    w_b_p0 = r_b[HALF_W-1:0];
    w_b_p1 = r_b[DATA_W-1:HALF_W];
    if (w_is_shift) begin
      w_b_p0 = w_b_sh;
      w_b_p1 = w_b_sh;
      if (w_big_sh) begin
        w_a_p0 = (r_op == ALU_OP_SRA) ? {HALF_W{r_a[DATA_W-1]}} : '0;
        w_a_p1 = (r_op == ALU_OP_SLL) ? w_a_lo : w_a_hi;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    bus.req_ready_o   = 1'b0;
    bus.resp_valid_o  = 1'b0;
    alu_first_cycle_o = 1'b0;
    alu_a_o           = '0;
    alu_b_o           = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) begin
          w_state_nxt = S_P0;
        end
      end
      S_P0: begin
        alu_first_cycle_o = 1'b1;
        alu_a_o           = w_a_p0;
        alu_b_o           = w_b_p0;
        w_state_nxt       = w_early ? S_RESP : S_P1;
      end
      S_P1: begin
        alu_a_o     = w_a_p1;
        alu_b_o     = w_b_p1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid_o = 1'b1;
        if (bus.resp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= ALU_OP_ADD;
      r_flip     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_cmp      <= 1'b0;
      r_cmp_held <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid_i) begin
            r_op       <= w_req_op;
            r_flip     <= bus.req_cmp_flip_i;
            r_a        <= bus.req_a_i;
            r_b        <= bus.req_b_i;
            r_result   <= '0;
            r_cmp      <= 1'b0;
            r_cmp_held <= 1'b0;
          end
        end
        S_P0: begin
          if (w_is_cmp) begin
            if (alu_cmp_result_valid_i) begin
              r_cmp      <= alu_cmp_result_i;
              r_cmp_held <= 1'b1;
            end
          end else if (w_hi_first) begin
            r_result[DATA_W-1:HALF_W] <= alu_result_i;
          end else begin
            r_result[HALF_W-1:0] <= alu_result_i;
          end
        end
        S_P1: begin
          // A compare settled in pass 0 keeps its value; otherwise pass 1 ends it.
          if (w_is_cmp) begin
            if (!r_cmp_held) begin
              r_cmp <= alu_cmp_result_i;
            end
          end else if (w_hi_first) begin
            r_result[HALF_W-1:0] <= alu_result_i;
          end else begin
            r_result[DATA_W-1:HALF_W] <= alu_result_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_op_o          = r_op;
  assign alu_cmp_flip_o    = r_flip;
  assign bus.resp_result_o = r_result;
  assign bus.resp_cmp_o    = r_cmp;

endmodule

// File: tb/tb_alu_sbm_seq.sv
// Scoreboard bench for alu_sbm_seq with a behavioural two-pass alu_sbm model.
module tb_alu_sbm_seq;
  import alu_sbm_pkg::*;

`ifdef ALU_SEQ_EARLY_CMP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sbm_seq_if #(.DATA_W(32)) bus ();

  cs_alu_op    alu_op;
  logic        alu_fc;
  logic        alu_flip;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_res;
  logic        alu_cmp;
  logic        alu_cmpv;

  alu_sbm_seq #(.DATA_W(32), .HALF_W(16)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .bus                    (bus),
    .alu_op_o               (alu_op),
    .alu_first_cycle_o      (alu_fc),
    .alu_cmp_flip_o         (alu_flip),
    .alu_a_o                (alu_a),
    .alu_b_o                (alu_b),
    .alu_result_i           (alu_res),
    .alu_cmp_result_i       (alu_cmp),
    .alu_cmp_result_valid_i (alu_cmpv)
  );

  // Serial ALU model: carry / shifted-out bits / partial compare kept between passes.
  logic        m_c, m_lt, m_eq, n_c, n_lt, n_eq;
  logic [15:0] m_sh, n_sh;

  always_comb begin
    logic [16:0] s;
    logic [31:0] w;
    s = '0; w = '0;
    alu_res = '0; alu_cmp = 1'b0; alu_cmpv = 1'b0;
    n_c = m_c; n_lt = m_lt; n_eq = m_eq; n_sh = m_sh;
    case (alu_op)
      ALU_OP_SUB: begin
        s = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'b0, (alu_fc ? 1'b1 : m_c)};
        alu_res = s[15:0]; n_c = s[16];
      end
      ALU_OP_PLUS_4: begin
        s = {1'b0, alu_a} + (alu_fc ? 17'd4 : 17'd0) + {16'b0, (alu_fc ? 1'b0 : m_c)};
        alu_res = s[15:0]; n_c = s[16];
      end
      ALU_OP_AND: alu_res = alu_a & alu_b;
      ALU_OP_OR:  alu_res = alu_a | alu_b;
      ALU_OP_XOR: alu_res = alu_a ^ alu_b;
      ALU_OP_EQ: begin
        n_eq     = (alu_a == alu_b) && (alu_fc || m_eq);
        alu_cmpv = alu_fc ? (alu_a != alu_b) : 1'b1;
        alu_cmp  = n_eq ^ alu_flip;
      end
      ALU_OP_LT, ALU_OP_LTU: begin
        if (alu_fc) begin
          n_lt = alu_a < alu_b;
        end else begin
          alu_cmpv = 1'b1;
          if (alu_op == ALU_OP_LT)
            alu_cmp = (($signed(alu_a) < $signed(alu_b)) || (alu_a == alu_b && m_lt)) ^ alu_flip;
          else
            alu_cmp = ((alu_a < alu_b) || (alu_a == alu_b && m_lt)) ^ alu_flip;
        end
      end
      ALU_OP_SLL: begin
        w = {16'b0, alu_a} << alu_b[3:0];
        alu_res = w[15:0] | (alu_fc ? 16'h0 : m_sh); n_sh = w[31:16];
      end
      ALU_OP_SRL, ALU_OP_SRA: begin
        if (alu_fc && alu_op == ALU_OP_SRA) w = $signed({alu_a, 16'b0}) >>> alu_b[3:0];
        else                                w = {alu_a, 16'b0} >> alu_b[3:0];
        alu_res = w[31:16] | (alu_fc ? 16'h0 : m_sh); n_sh = w[15:0];
      end
      default: begin
        s = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, (alu_fc ? 1'b0 : m_c)};
        alu_res = s[15:0]; n_c = s[16];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    m_c <= n_c; m_lt <= n_lt; m_eq <= n_eq; m_sh <= n_sh;
  end

  typedef struct {
    logic [31:0] res;
    logic        cmp;
    int          lat;
    int          acc;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   first_v = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] ref_op(input cs_alu_op op, input logic [31:0] a,
                                         input logic [31:0] b, input logic flip);
    case (op)
      ALU_OP_SUB:    return {1'b0, a - b};
      ALU_OP_PLUS_4: return {1'b0, a + 32'd4};
      ALU_OP_AND:    return {1'b0, a & b};
      ALU_OP_OR:     return {1'b0, a | b};
      ALU_OP_XOR:    return {1'b0, a ^ b};
      ALU_OP_EQ:     return {(a == b) ^ flip, 32'h0};
      ALU_OP_LT:     return {($signed(a) < $signed(b)) ^ flip, 32'h0};
      ALU_OP_LTU:    return {(a < b) ^ flip, 32'h0};
      ALU_OP_SLL:    return {1'b0, a << b[4:0]};
      ALU_OP_SRL:    return {1'b0, a >> b[4:0]};
      ALU_OP_SRA:    return {1'b0, 32'($signed(a) >>> b[4:0])};
      default:       return {1'b0, a + b};
    endcase
  endfunction

  function automatic int exp_lat(input cs_alu_op op, input logic [31:0] a, input logic [31:0] b);
    return (EARLY && op == ALU_OP_EQ && a[15:0] != b[15:0]) ? 2 : 3;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      first_v = -1;
    end else if (bus.resp_valid_o) begin
      if (first_v < 0) first_v = cyc;
      if (bus.resp_ready_i) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.tag, "_res"}, bus.resp_result_o, e.res);
          chk({e.tag, "_cmp"}, {31'b0, bus.resp_cmp_o}, {31'b0, e.cmp});
          chk({e.tag, "_lat"}, 32'(first_v - e.acc), 32'(e.lat));
        end
        first_v = -1;
      end
    end
  end

  task automatic send(input cs_alu_op op, input logic [31:0] a, input logic [31:0] b,
                      input logic flip, input string tag);
    int w;
    logic [32:0] r;
    exp_t e;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_op_i = op; bus.req_a_i = a;
    bus.req_b_i = b; bus.req_cmp_flip_i = flip;
    w = 0;
    while (!bus.req_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready_o) begin
      chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
      bus.req_valid_i = 1'b0;
      return;
    end
    r = ref_op(op, a, b, flip);
    e.res = r[31:0]; e.cmp = r[32]; e.lat = exp_lat(op, a, b); e.acc = cyc; e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    int          w;
    int          seen;
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_op_i = ALU_OP_ADD; bus.req_a_i = '0;
    bus.req_b_i = '0; bus.req_cmp_flip_i = 1'b0; bus.resp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready",  {31'b0, bus.req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
    chk("rst_result",     bus.resp_result_o, 32'd0);
    chk("rst_cmp",        {31'b0, bus.resp_cmp_o}, 32'd0);
    chk("rst_first",      {31'b0, alu_fc}, 32'd0);
    chk("rst_alu_op",     {28'b0, alu_op}, {28'b0, ALU_OP_ADD});
    chk("rst_alu_a",      {16'b0, alu_a}, 32'd0);
    chk("rst_alu_b",      {16'b0, alu_b}, 32'd0);

    send(ALU_OP_ADD, 32'h0000_FFFF, 32'h1, 1'b0, "add_carry");
    send(ALU_OP_SUB, 32'h0001_0000, 32'h1, 1'b0, "sub_borrow");
    send(ALU_OP_LTU, 32'h1, 32'h2, 1'b0, "ltu");
    send(ALU_OP_LT, 32'hFFFF_FFFF, 32'h0, 1'b0, "lt_neg");
    send(ALU_OP_LT, 32'hFFFF_FFFF, 32'h0, 1'b1, "lt_flip");
    send(ALU_OP_LTU, 32'h0001_0001, 32'h0001_0002, 1'b0, "ltu_hieq");
    send(ALU_OP_SRL, 32'h8000_0001, 32'd4, 1'b0, "srl4");
    send(ALU_OP_SRA, 32'h8000_0001, 32'd20, 1'b0, "sra20");
    send(ALU_OP_SLL, 32'h1, 32'd17, 1'b0, "sll17");
    send(ALU_OP_SRL, 32'hDEAD_BEEF, 32'd16, 1'b0, "srl16");
    send(ALU_OP_SRA, 32'h8765_4321, 32'd31, 1'b0, "sra31");
    send(ALU_OP_SLL, 32'hCAFE_F00D, 32'd0, 1'b0, "sll0");
    send(ALU_OP_SRL, 32'hCAFE_F00D, 32'hFFFF_FFE0, 1'b0, "srl_hib");
    send(ALU_OP_EQ, 32'h0001_0000, 32'h0, 1'b0, "eq_hidiff");
    send(ALU_OP_EQ, 32'h1234_5678, 32'h1234_5678, 1'b0, "eq_same");
    send(ALU_OP_EQ, 32'h0000_0001, 32'h0, 1'b0, "eq_lodiff");
    send(ALU_OP_EQ, 32'h0000_0001, 32'h0, 1'b1, "ne_lodiff");
    send(ALU_OP_PLUS_4, 32'hFFFF_FFFE, 32'h5555, 1'b0, "plus4");
    send(ALU_OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, "and");
    send(ALU_OP_OR, 32'hF000_0001, 32'h0F00_0010, 1'b0, "or");
    send(cs_alu_op'(4'd13), 32'h0000_FFFF, 32'h0000_0003, 1'b0, "unlisted");
    drain();

    for (int i = 0; i < 40; i++) begin
      cs_alu_op    op;
      logic [31:0] a, b;
      op = cs_alu_op'(4'($urandom_range(0, 13)));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      send(op, a, b, 1'($urandom_range(0, 1)), "rand");
    end
    drain();

    bus.resp_ready_i = 1'b0;
    send(ALU_OP_XOR, 32'hA5A5_0F0F, 32'hFFFF_00FF, 1'b0, "hold");
    w = 0;
    while (!bus.resp_valid_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    held = bus.resp_result_o;
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", {31'b0, bus.resp_valid_o}, 32'd1);
      chk("hold_result", bus.resp_result_o, 32'h5A5A_0FF0);
      chk("hold_stable", bus.resp_result_o, held);
      chk("hold_req_ready", {31'b0, bus.req_ready_o}, 32'd0);
      @(negedge clk);
    end
    bus.resp_ready_i = 1'b1;
    drain();

    send(ALU_OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0, "rst_p1");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    q.delete();
    chk("rstp1_resp_valid", {31'b0, bus.resp_valid_o}, 32'd0);
    chk("rstp1_req_ready", {31'b0, bus.req_ready_o}, 32'd1);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid_o) seen++;
    end
    chk("rstp1_no_resp", 32'(seen), 32'd0);
    send(ALU_OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, "after_rst");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
